// File: rtl/fbus_regfile.sv
// MCU strobe-bus register file: synchronised writes land in shadow registers and
// commit atomically to the live bank when fcs deasserts. Readback port: FBUS_READBACK_EN.
module fbus_regfile #(
    parameter int unsigned   DW      = 16,
    parameter int unsigned   AW      = 3,
    parameter int unsigned   NREG    = 8,
    parameter logic [DW-1:0] RST_VAL = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DW-1:0]        fdata,
    input  logic [AW-1:0]        faddr,
    input  logic                 fclk,
    input  logic                 fcs,
`ifdef FBUS_READBACK_EN
    input  logic                 frd,
    output logic [DW-1:0]        fq,
    output logic                 fq_oe,
`endif
    output logic [NREG*DW-1:0]   regs_flat,
    output logic                 upd,
    output logic [NREG-1:0]      upd_mask,
    output logic [7:0]           wr_cnt,
    output logic                 err_addr
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEL,
        ST_COMMIT
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [2:0]      r_fclk_s;
    logic [2:0]      r_fcs_s;
    logic [DW-1:0]   r_fdata_d0;
    logic [DW-1:0]   r_fdata_d1;
    logic [AW-1:0]   r_faddr_d0;
    logic [AW-1:0]   r_faddr_d1;
    logic [AW-1:0]   r_addr_q;
    logic            r_post_rst;
    logic            r_cs_armed;
    logic            r_csf_pend;

    logic [DW-1:0]   r_shadow [NREG];
    logic [DW-1:0]   r_live   [NREG];
    logic [NREG-1:0] r_dirty;
    logic [7:0]      r_cnt;
    logic            r_upd;
    logic [NREG-1:0] r_upd_mask;
    logic [7:0]      r_wr_cnt;
    logic            r_err;

    logic w_fall;
    logic w_csr;
    logic w_csf;
    logic w_addr_ok;
    logic w_wr;

    // Bit 0 is s0 (pin side), bit 2 is s2; data/address pairs stay aligned with s1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fclk_s   <= '0;
            r_fcs_s    <= '1;
            r_fdata_d0 <= '0;
            r_fdata_d1 <= '0;
            r_faddr_d0 <= '0;
            r_faddr_d1 <= '0;
            r_addr_q   <= '0;
            r_post_rst <= 1'b0;
            r_cs_armed <= 1'b0;
        end else begin
            r_fclk_s   <= {r_fclk_s[1:0], fclk};
            r_fcs_s    <= {r_fcs_s[1:0], fcs};
            r_fdata_d0 <= fdata;
            r_fdata_d1 <= r_fdata_d0;
            r_faddr_d0 <= faddr;
            r_faddr_d1 <= r_faddr_d0;
            if (r_fclk_s[1] && !r_fcs_s[1]) begin
                r_addr_q <= r_faddr_d1;
            end
            r_post_rst <= 1'b1;
            // A select that was already low across reset must not open a transaction.
            if (r_post_rst && r_fcs_s[0]) begin
                r_cs_armed <= 1'b1;
            end
        end
    end

    assign w_fall    = r_fclk_s[2] & ~r_fclk_s[1];
    assign w_csr     = ~r_fcs_s[2] & r_fcs_s[1];
    assign w_csf     = r_fcs_s[2] & ~r_fcs_s[1] & r_cs_armed;
    assign w_addr_ok = (32'(r_addr_q) < NREG);
    assign w_wr      = (r_state == ST_SEL) && w_fall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_csf_pend <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_csf_pend <= (r_state == ST_COMMIT) && w_csf;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_csf || r_csf_pend) w_state_nxt = ST_SEL;
            ST_SEL:    if (w_csr) w_state_nxt = ST_COMMIT;
            ST_COMMIT: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                r_shadow[i] <= RST_VAL;
                r_live[i]   <= RST_VAL;
            end
            r_dirty    <= '0;
            r_cnt      <= '0;
            r_upd      <= 1'b0;
            r_upd_mask <= '0;
            r_wr_cnt   <= '0;
            r_err      <= 1'b0;
        end else begin
            r_upd <= 1'b0;
            if (w_wr) begin
                if (w_addr_ok) begin
                    for (int unsigned i = 0; i < NREG; i++) begin
                        if (r_addr_q == AW'(i)) begin
                            r_shadow[i] <= r_fdata_d1;
                            r_dirty[i]  <= 1'b1;
                        end
                    end
                    if (r_cnt != 8'hFF) begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end else begin
                    r_err <= 1'b1;
                end
            end
            if (r_state == ST_COMMIT) begin
                for (int unsigned i = 0; i < NREG; i++) begin
                    if (r_dirty[i]) begin
                        r_live[i] <= r_shadow[i];
                    end
                end
                r_upd_mask <= r_dirty;
                r_wr_cnt   <= r_cnt;
                r_upd      <= |r_dirty;
                r_dirty    <= '0;
                r_cnt      <= '0;
                if (|r_dirty) begin
                    r_err <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        regs_flat = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            regs_flat[i*DW +: DW] = r_live[i];
        end
    end

    assign upd      = r_upd;
    assign upd_mask = r_upd_mask;
    assign wr_cnt   = r_wr_cnt;
    assign err_addr = r_err;

`ifdef FBUS_READBACK_EN
    logic [1:0]    r_frd_s;
    logic [DW-1:0] r_fq;
    logic          r_fq_oe;
    logic [DW-1:0] w_rd_word;
    logic          w_rd_en;

    // Unmatched (out-of-range) addresses fall through to zero.
    always_comb begin
        w_rd_word = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            if (r_addr_q == AW'(i)) begin
                w_rd_word = r_live[i];
            end
        end
    end

    assign w_rd_en = ~r_fcs_s[1] & r_frd_s[1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_frd_s <= '0;
            r_fq    <= '0;
            r_fq_oe <= 1'b0;
        end else begin
            r_frd_s <= {r_frd_s[0], frd};
            r_fq_oe <= w_rd_en;
            if (w_rd_en) begin
                r_fq <= w_rd_word;
            end
        end
    end

    assign fq    = r_fq;
    assign fq_oe = r_fq_oe;
`endif

endmodule

// File: tb/tb_fbus_regfile.sv
// Randomised bench for fbus_regfile against a transaction-level model of the
// shadow/commit behaviour (NREG=6 so addresses 6 and 7 exercise err_addr).
module tb_fbus_regfile;

    localparam int unsigned DW   = 16;
    localparam int unsigned AW   = 3;
    localparam int unsigned NREG = 6;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [DW-1:0]       fdata;
    logic [AW-1:0]       faddr;
    logic                fclk;
    logic                fcs;
    logic [NREG*DW-1:0]  regs_flat;
    logic                upd;
    logic [NREG-1:0]     upd_mask;
    logic [7:0]          wr_cnt;
    logic                err_addr;
`ifdef FBUS_READBACK_EN
    logic                frd;
    logic [DW-1:0]       fq;
    logic                fq_oe;
`endif

    fbus_regfile #(
        .DW(DW), .AW(AW), .NREG(NREG), .RST_VAL(16'h0000)
    ) dut (
        .clk(clk), .rst_n(rst_n), .fdata(fdata), .faddr(faddr),
        .fclk(fclk), .fcs(fcs),
`ifdef FBUS_READBACK_EN
        .frd(frd), .fq(fq), .fq_oe(fq_oe),
`endif
        .regs_flat(regs_flat), .upd(upd), .upd_mask(upd_mask),
        .wr_cnt(wr_cnt), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Model: committed bank plus the writes pending in the open transaction.
    logic [DW-1:0]   m_live [NREG];
    logic [DW-1:0]   p_data [NREG];
    logic [NREG-1:0] p_dirty;
    int unsigned     p_cnt;
    logic            p_bad;
    logic [NREG-1:0] m_mask;
    logic [7:0]      m_cnt;
    logic            m_err;
    logic            m_upd;

    int unsigned        obs_upd_n;
    logic [NREG*DW-1:0] obs_pre;
    logic [NREG*DW-1:0] obs_at;
    logic [NREG-1:0]    obs_mask;
    logic [7:0]         obs_wrcnt;
    logic               obs_err;
    logic [NREG*DW-1:0] old_flat;

    function automatic logic [NREG*DW-1:0] m_flat();
        logic [NREG*DW-1:0] f;
        for (int i = 0; i < int'(NREG); i++) f[i*DW +: DW] = m_live[i];
        return f;
    endfunction

    task automatic model_discard();
        p_dirty = '0; p_cnt = 0; p_bad = 1'b0;
        for (int i = 0; i < int'(NREG); i++) p_data[i] = '0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(NREG); i++) m_live[i] = '0;
        m_mask = '0; m_cnt = '0; m_err = 1'b0; m_upd = 1'b0;
        model_discard();
    endtask

    task automatic model_write(input int unsigned a, input logic [DW-1:0] d);
        if (a < NREG) begin
            p_data[a] = d; p_dirty[a] = 1'b1; p_cnt++;
        end else begin
            p_bad = 1'b1;
        end
    endtask

    task automatic model_commit();
        for (int i = 0; i < int'(NREG); i++) if (p_dirty[i]) m_live[i] = p_data[i];
        m_upd  = (p_dirty != '0);
        m_err  = m_upd ? 1'b0 : (m_err | p_bad);
        m_mask = p_dirty;
        m_cnt  = (p_cnt > 255) ? 8'd255 : 8'(p_cnt);
        model_discard();
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic cs_open();
        fcs = 1'b0;
        wait_clk(4);
    endtask

    task automatic bus_write(input int unsigned a, input logic [DW-1:0] d);
        model_write(a, d);
        faddr = AW'(a); fdata = d; fclk = 1'b1;
        wait_clk(4);
        fclk = 1'b0;
        wait_clk(4);
    endtask

    // Raises fcs (optionally together with the final fclk fall) and records the commit.
    task automatic cs_close(input bit with_fall);
        bit got;
        got = 1'b0;
        old_flat = m_flat();
        fcs = 1'b1;
        if (with_fall) fclk = 1'b0;
        obs_upd_n = 0;
        obs_pre = regs_flat;
        obs_at  = regs_flat;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (upd) begin
                obs_upd_n++;
                if (!got) begin obs_at = regs_flat; got = 1'b1; end
            end else if (!got) begin
                obs_pre = regs_flat; obs_at = regs_flat;
            end
        end
        obs_mask = upd_mask; obs_wrcnt = wr_cnt; obs_err = err_addr;
        wait_clk(2);
        model_commit();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; fcs = 1'b1; fclk = 1'b0; faddr = '0; fdata = '0;
`ifdef FBUS_READBACK_EN
        frd = 1'b0;
`endif
        wait_clk(3);
        rst_n = 1'b1;
        model_reset();
        wait_clk(3);
        @(negedge clk);
        checks++; if (regs_flat !== m_flat()) begin errors++; $display("FAIL reset_regs: got %h exp %h", regs_flat, m_flat()); end
        checks++; if (upd !== 1'b0) begin errors++; $display("FAIL reset_upd: got %b exp 0", upd); end
        checks++; if (upd_mask !== '0) begin errors++; $display("FAIL reset_mask: got %h exp 0", upd_mask); end
        checks++; if (wr_cnt !== 8'd0) begin errors++; $display("FAIL reset_wrcnt: got %0d exp 0", wr_cnt); end
        checks++; if (err_addr !== 1'b0) begin errors++; $display("FAIL reset_err: got %b exp 0", err_addr); end
        wait_clk(1);
    endtask

    task automatic test_single_write();
        cs_open();
        bus_write(1, 16'h1234);
        cs_close(1'b0);
        checks++; if (obs_upd_n != 1) begin errors++; $display("FAIL single_upd_pulses: got %0d exp 1", obs_upd_n); end
        checks++; if (obs_pre !== old_flat) begin errors++; $display("FAIL single_early: got %h exp %h", obs_pre, old_flat); end
        checks++; if (obs_at[31:16] !== 16'h1234) begin errors++; $display("FAIL single_reg1: got %h exp 1234", obs_at[31:16]); end
        checks++; if (obs_mask !== 6'h02) begin errors++; $display("FAIL single_mask: got %h exp 02", obs_mask); end
        checks++; if (obs_wrcnt !== 8'd1) begin errors++; $display("FAIL single_wrcnt: got %0d exp 1", obs_wrcnt); end
    endtask

    task automatic test_atomic_pair();
        cs_open();
        bus_write(2, 16'hBEEF);
        bus_write(3, 16'h0001);
        cs_close(1'b0);
        checks++; if (obs_upd_n != 1) begin errors++; $display("FAIL pair_upd_pulses: got %0d exp 1", obs_upd_n); end
        checks++; if (obs_pre !== old_flat) begin errors++; $display("FAIL pair_early: got %h exp %h", obs_pre, old_flat); end
        checks++; if (obs_at !== m_flat()) begin errors++; $display("FAIL pair_regs: got %h exp %h", obs_at, m_flat()); end
        checks++; if (obs_mask !== 6'h0C) begin errors++; $display("FAIL pair_mask: got %h exp 0C", obs_mask); end
        checks++; if (obs_wrcnt !== 8'd2) begin errors++; $display("FAIL pair_wrcnt: got %0d exp 2", obs_wrcnt); end
    endtask

    task automatic test_bad_addr();
        cs_open();
        bus_write(7, 16'hDEAD);
        cs_close(1'b0);
        checks++; if (obs_err !== 1'b1) begin errors++; $display("FAIL bad_err_set: got %b exp 1", obs_err); end
        checks++; if (obs_upd_n != 0) begin errors++; $display("FAIL bad_no_upd: got %0d exp 0", obs_upd_n); end
        checks++; if (obs_at !== old_flat) begin errors++; $display("FAIL bad_bank_kept: got %h exp %h", obs_at, old_flat); end
        checks++; if (obs_mask !== '0) begin errors++; $display("FAIL bad_mask: got %h exp 0", obs_mask); end
        cs_open();
        bus_write(0, 16'h00AA);
        cs_close(1'b0);
        checks++; if (obs_upd_n != 1) begin errors++; $display("FAIL bad_follow_upd: got %0d exp 1", obs_upd_n); end
        checks++; if (obs_err !== 1'b0) begin errors++; $display("FAIL bad_err_clear: got %b exp 0", obs_err); end
        checks++; if (obs_at !== m_flat()) begin errors++; $display("FAIL bad_follow_regs: got %h exp %h", obs_at, m_flat()); end
    endtask

    task automatic test_coincident();
        cs_open();
        bus_write(4, 16'h0F0F);
        model_write(5, 16'h5A5A);
        faddr = 3'd5; fdata = 16'h5A5A; fclk = 1'b1;
        wait_clk(4);
        cs_close(1'b1);
        checks++; if (obs_upd_n != 1) begin errors++; $display("FAIL coinc_upd: got %0d exp 1", obs_upd_n); end
        checks++; if (obs_at !== m_flat()) begin errors++; $display("FAIL coinc_regs: got %h exp %h", obs_at, m_flat()); end
        checks++; if (obs_mask !== 6'h30) begin errors++; $display("FAIL coinc_mask: got %h exp 30", obs_mask); end
        checks++; if (obs_wrcnt !== 8'd2) begin errors++; $display("FAIL coinc_wrcnt: got %0d exp 2", obs_wrcnt); end
    endtask

    task automatic test_reset_mid();
        cs_open();
        bus_write(0, 16'h5555);
        rst_n = 1'b0;
        wait_clk(1);
        rst_n = 1'b1;
        model_reset();
        bus_write(1, 16'h7777);
        model_discard();
        cs_close(1'b0);
        checks++; if (obs_upd_n != 0) begin errors++; $display("FAIL rstmid_no_upd: got %0d exp 0", obs_upd_n); end
        checks++; if (obs_at !== m_flat()) begin errors++; $display("FAIL rstmid_regs: got %h exp %h", obs_at, m_flat()); end
        checks++; if (obs_wrcnt !== 8'd0) begin errors++; $display("FAIL rstmid_wrcnt: got %0d exp 0", obs_wrcnt); end
        checks++; if (obs_mask !== '0) begin errors++; $display("FAIL rstmid_mask: got %h exp 0", obs_mask); end
        cs_open();
        bus_write(2, 16'h1111);
        cs_close(1'b0);
        checks++; if (obs_upd_n != 1) begin errors++; $display("FAIL rstmid_rearm_upd: got %0d exp 1", obs_upd_n); end
        checks++; if (obs_at !== m_flat()) begin errors++; $display("FAIL rstmid_rearm_regs: got %h exp %h", obs_at, m_flat()); end
    endtask

    task automatic test_random();
        for (int t = 0; t < 20; t++) begin
            int unsigned n;
            n = $urandom_range(0, 4);
            cs_open();
            for (int w = 0; w < int'(n); w++) bus_write($urandom_range(0, 7), DW'($urandom));
            cs_close(1'b0);
            checks++; if (obs_upd_n != (m_upd ? 1 : 0)) begin errors++; $display("FAIL rand%0d_upd: got %0d exp %0d", t, obs_upd_n, m_upd); end
            checks++; if (obs_pre !== old_flat) begin errors++; $display("FAIL rand%0d_early: got %h exp %h", t, obs_pre, old_flat); end
            checks++; if (obs_at !== m_flat()) begin errors++; $display("FAIL rand%0d_regs: got %h exp %h", t, obs_at, m_flat()); end
            checks++; if (obs_mask !== m_mask) begin errors++; $display("FAIL rand%0d_mask: got %h exp %h", t, obs_mask, m_mask); end
            checks++; if (obs_wrcnt !== m_cnt) begin errors++; $display("FAIL rand%0d_wrcnt: got %0d exp %0d", t, obs_wrcnt, m_cnt); end
            checks++; if (obs_err !== m_err) begin errors++; $display("FAIL rand%0d_err: got %b exp %b", t, obs_err, m_err); end
        end
    endtask

    task automatic test_saturation();
        cs_open();
        for (int w = 0; w < 260; w++) bus_write(5, DW'(w));
        cs_close(1'b0);
        checks++; if (obs_wrcnt !== 8'd255) begin errors++; $display("FAIL sat_wrcnt: got %0d exp 255", obs_wrcnt); end
        checks++; if (obs_upd_n != 1) begin errors++; $display("FAIL sat_upd: got %0d exp 1", obs_upd_n); end
        checks++; if (obs_at !== m_flat()) begin errors++; $display("FAIL sat_regs: got %h exp %h", obs_at, m_flat()); end
    endtask

`ifdef FBUS_READBACK_EN
    task automatic test_readback();
        bit seen;
        cs_open();
        bus_write(4, 16'hCAFE);
        cs_close(1'b0);
        fcs = 1'b0; faddr = 3'd4; fclk = 1'b1; frd = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 6 && !seen; k++) begin
            @(negedge clk);
            if (fq_oe === 1'b1) seen = 1'b1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL rd_oe_timeout: got fq_oe=%b exp 1", fq_oe); end
        checks++; if (fq !== m_live[4]) begin errors++; $display("FAIL rd_data: got %h exp %h", fq, m_live[4]); end
        frd = 1'b0;
        wait_clk(4);
        @(negedge clk);
        checks++; if (fq_oe !== 1'b0) begin errors++; $display("FAIL rd_oe_off: got %b exp 0", fq_oe); end
        cs_close(1'b0);
        fclk = 1'b0;
        wait_clk(4);
    endtask
`endif

    initial begin
        test_reset();
        test_single_write();
        test_atomic_pair();
        test_bad_addr();
        test_coincident();
        test_reset_mid();
        test_random();
        test_saturation();
`ifdef FBUS_READBACK_EN
        test_readback();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fbus_regfile.md
# fbus_regfile

Parametrised MCU parallel-bus register file for the sine-generator FPGA. An external MCU writes `NREG` words of `DW` bits over an asynchronous strobe bus (`fcs`, `fclk`, `faddr`, `fdata`). Writes land in shadow registers and are committed atomically to the live register bank when `fcs` deasserts. The block replaces the fixed two-word (mode + 32-bit frequency) capture with an addressed, double-buffered bank that has dirty tracking, an update strobe and error reporting. Downstream NCO and mode logic read `regs_flat`.

## Interface
- `DW`, default 16: data word width, 8..32.
- `AW`, default 3: address width.
- `NREG`, default 8: number of registers, 1..2^AW.
- `RST_VAL`, default 0: reset value of every shadow and live register (DW bits).
- `clk` in 1: system clock; the only clock.
- `rst_n` in 1: synchronous, active-low reset.
- `fdata` in DW: MCU data bus, asynchronous.
- `faddr` in AW: MCU register address, asynchronous.
- `fclk` in 1: MCU write strobe, asynchronous; data is taken on its falling edge.
- `fcs` in 1: MCU chip select, active low, asynchronous.
- `regs_flat` out NREG*DW: live registers; register i occupies bits [i*DW +: DW].
- `upd` out 1: one-cycle pulse when the live bank changes.
- `upd_mask` out NREG: registers changed by the last commit; held until the next commit.
- `wr_cnt` out 8: writes accepted in the last transaction; saturates at 255.
- `err_addr` out 1: sticky flag, set by a write to an address ≥ NREG.

## Operation
- **Synchronisers.** `fclk` and `fcs` each pass through a 3-flop chain (s0, s1, s2). `fdata` and `faddr` are registered twice so they stay aligned with s1.
- **Edge detection.** Edges are decoded from the (s2, s1) pair:
  - `fall = s2 & ~s1` on `fclk`.
  - `csr = ~s2 & s1` on `fcs` (rising edge).
  - `csf = s2 & ~s1` on `fcs` (falling edge).
- **Address latch.** `addr_q` loads the aligned `faddr` on every cycle where synced `fclk` = 1 and synced `fcs` = 0.
- **FSM states:** IDLE, SEL, COMMIT.
  - IDLE → SEL on `csf`.
  - SEL → COMMIT on `csr`.
  - COMMIT → IDLE unconditionally after 1 cycle.
  - A `csf` seen while in COMMIT is taken after the return to IDLE; SEL entry can occur 1 cycle late.
- **Write (in SEL).** On `fall`:
  - `addr_q` < NREG: shadow[`addr_q`] ← aligned `fdata`, set `dirty[addr_q]`, and `cnt` += 1 (saturating).
  - `addr_q` ≥ NREG: set `err_addr`; no shadow change.
  - Repeated writes to one address: the last value wins.
  - `fall` in IDLE or COMMIT is ignored.
- **Commit (in COMMIT).** For every i with `dirty[i]`: live[i] ← shadow[i].
  - `upd_mask` ← `dirty`, `wr_cnt` ← `cnt`.
  - `upd` = 1 only if `dirty` ≠ 0.
  - Then `dirty` ← 0 and `cnt` ← 0.
- **Simultaneous `fall` and `csr` in SEL.** The write is performed and included in the commit: its dirty bit and data are visible to COMMIT on the next cycle.
- **`err_addr`.** Sticky; cleared only by reset or by a commit in which `dirty` ≠ 0.
- **Reset values** (`rst_n` = 0 at a `clk` edge):
  - State = IDLE.
  - All shadow and live registers = `RST_VAL`.
  - `dirty`, `cnt`, `upd`, `upd_mask`, `wr_cnt`, `err_addr` = 0.
  - Synchroniser flops: `fclk` chain = 0, `fcs` chain = 1.
- **Reset mid-transaction.** The pending shadow contents are discarded and no commit occurs. If `fcs` is still low after reset is released, writes are ignored until the next `csf`.

## Timing
- `fclk` falling at the pin → shadow written 3–4 `clk` edges later (synchroniser uncertainty).
- `fcs` rising at the pin → live bank and `upd` change 4–5 edges later: sync, detect, COMMIT register.
- `upd` is high in the same cycle that the new `regs_flat` values first appear.
- MCU constraints:
  - `fclk` high and low phases ≥ 4 `clk` periods each.
  - `fdata`/`faddr` stable from ≥ 3 `clk` before to ≥ 1 `clk` after the `fclk` falling edge.
  - `fcs` high for ≥ 4 `clk` between transactions.
- All outputs are registered; there is no combinational path from any input to any output.

## Configuration
- Macro: `FBUS_READBACK_EN`.
- **Defined.** Adds:
  - Input `frd` (1 bit): read strobe, asynchronous, synchronised like `fclk`.
  - Output `fq` [DW-1:0]: registered; loads live[`addr_q`] on every cycle with synced `fcs` = 0 and synced `frd` = 1. An address ≥ NREG returns 0. Reset value 0.
  - Output `fq_oe` (1 bit): registered copy of (synced `fcs` = 0 & synced `frd` = 1), for the top-level tristate.
- **Undefined.** None of these ports exist; the bank is write-only.

## Test plan
- **Single-register write.** Reset; transaction writing addr 1 = 0x1234; `fcs` released → `regs_flat[31:16]` = 0x1234, a single 1-cycle `upd` pulse, `upd_mask` = 8'h02, `wr_cnt` = 1. The value is not visible before `upd`.
- **Atomic 32-bit frequency word.** Write addr 2 = 0xBEEF, then addr 3 = 0x0001 in one transaction → both words change in the same cycle, `upd_mask` = 8'h0C, `wr_cnt` = 2.
- **Bad address and empty transaction.**
  - Write to addr 7 with NREG = 6 → `err_addr` = 1, no `upd`, live bank unchanged.
  - A later transaction writing addr 0 = 0x00AA → `upd`, and `err_addr` cleared.
- **Last `fclk` fall coincident with `fcs` rise.** The last `fclk` falling edge and the `fcs` rising edge arrive in the same `clk` cycle after sync → that write is committed; `wr_cnt` includes it.
- **Reset mid-transaction.** `rst_n` = 0 for 1 cycle after writing addr 0 = 0x5555 and before `fcs` rises → live[0] = 0, no `upd`, and writes in the remaining low-`fcs` window are ignored.
- **Readback (`FBUS_READBACK_EN` defined).** After committing addr 4 = 0xCAFE, drive `fcs` low, `faddr` = 4, `fclk` high, `frd` high → `fq` = 0xCAFE with `fq_oe` = 1 within 4 cycles; with `frd` low, `fq_oe` = 0.
